// File: rtl/memory_stage.sv
// Pipeline memory stage: data-memory access, stack pointer, CALL/RET/RTI stack sequencing and write-back registers.
// Optional RTI flags pop is enabled with `define MEM_RTI_FLAGS_EN (adds FlagsLoad/FlagsValue ports).
module memory_stage #(
    parameter int ADDR_W = 20,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [105:0]      ExIn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       MemWData,
    output logic              MemWE,
    output logic              MemRE,
    input  logic [15:0]       MemRData,
    output logic              Stall,
    output logic              WbEn,
    output logic [2:0]        WbAddr,
    output logic [15:0]       WbData,
    output logic [19:0]       FwdMem,
    output logic              PcLoad,
    output logic [31:0]       PcValue,
    output logic [15:0]       OutPort,
    output logic [ADDR_W-1:0] SP
`ifdef MEM_RTI_FLAGS_EN
    ,
    output logic              FlagsLoad,
    output logic [2:0]        FlagsValue
`endif
);

`ifdef MEM_RTI_FLAGS_EN
    typedef enum logic [1:0] {IDLE, CALL_LO, RET_HI, RTI_F} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALL_LO, RET_HI} state_t;
`endif

    logic [15:0] inPort, rsrcVal, aluRes;
    logic [31:0] nextPc;
    logic [2:0]  rdstAddr;
    logic fPush, fPop, fRet, fRti, fLdd, fIn, fOut, fCall, fMemWrite, fWb;
    logic unusedBits;

    assign inPort    = ExIn[98:83];
    assign nextPc    = ExIn[82:51];
    assign rsrcVal   = ExIn[50:35];
    assign aluRes    = ExIn[34:19];
    assign rdstAddr  = ExIn[15:13];
    assign fPush     = ExIn[11];
    assign fPop      = ExIn[10];
    assign fRet      = ExIn[9];
    assign fRti      = ExIn[8];
    assign fLdd      = ExIn[7];
    assign fIn       = ExIn[6];
    assign fOut      = ExIn[5];
    assign fCall     = ExIn[3];
    assign fMemWrite = ExIn[1];
    assign fWb       = ExIn[0];
    assign unusedBits = ^{ExIn[105:99], ExIn[18:16], ExIn[12], ExIn[4], ExIn[2]};

    state_t stateReg, stateNext;
    logic [ADDR_W-1:0] spReg, spNext, spInc, spDec, aluAddr;
    logic [15:0] lowReg, lowNext, callLoReg, callLoNext, targetReg, targetNext;
    logic        wbEnReg, wbEnNext;
    logic [2:0]  wbAddrReg, wbAddrNext;
    logic [15:0] wbDataReg, wbDataNext, outPortReg, outPortNext;
    logic        pcLoadReg, pcLoadNext;
    logic [31:0] pcValueReg, pcValueNext;
    logic        memWeC, memReC, stallC;
`ifdef MEM_RTI_FLAGS_EN
    logic        rtiReg, rtiNext, flagsLoadReg, flagsLoadNext;
    logic [2:0]  flagsValueReg, flagsValueNext;
`endif

    assign spInc   = spReg + ADDR_W'(1);
    assign spDec   = spReg - ADDR_W'(1);
    assign aluAddr = {{(ADDR_W-16){1'b0}}, aluRes};

    always_comb begin
        stateNext   = stateReg;
        spNext      = spReg;
        MemAddr     = '0;
        MemWData    = '0;
        memWeC      = 1'b0;
        memReC      = 1'b0;
        stallC      = 1'b0;
        lowNext     = lowReg;
        callLoNext  = callLoReg;
        targetNext  = targetReg;
        wbEnNext    = 1'b0;
        wbAddrNext  = wbAddrReg;
        wbDataNext  = wbDataReg;
        outPortNext = outPortReg;
        pcLoadNext  = 1'b0;
        pcValueNext = pcValueReg;
`ifdef MEM_RTI_FLAGS_EN
        rtiNext        = rtiReg;
        flagsLoadNext  = 1'b0;
        flagsValueNext = flagsValueReg;
`endif
        case (stateReg)
            IDLE: begin
                if (fCall) begin
                    MemAddr    = spReg;
                    MemWData   = nextPc[31:16];
                    memWeC     = 1'b1;
                    spNext     = spDec;
                    stallC     = 1'b1;
                    callLoNext = nextPc[15:0];
                    targetNext = aluRes;
                    stateNext  = CALL_LO;
                end else if (fRet || fRti) begin
                    spNext    = spInc;
                    MemAddr   = spInc;
                    memReC    = 1'b1;
                    lowNext   = MemRData;
                    stallC    = 1'b1;
                    stateNext = RET_HI;
`ifdef MEM_RTI_FLAGS_EN
                    rtiNext   = !fRet;
`endif
                end else if (fPush) begin
                    MemAddr  = spReg;
                    MemWData = rsrcVal;
                    memWeC   = 1'b1;
                    spNext   = spDec;
                end else if (fPop) begin
                    spNext     = spInc;
                    MemAddr    = spInc;
                    memReC     = 1'b1;
                    wbEnNext   = 1'b1;
                    wbAddrNext = rdstAddr;
                    wbDataNext = MemRData;
                end else if (fLdd) begin
                    MemAddr    = aluAddr;
                    memReC     = 1'b1;
                    wbEnNext   = fWb;
                    wbAddrNext = rdstAddr;
                    wbDataNext = MemRData;
                end else if (fMemWrite) begin
                    MemAddr  = aluAddr;
                    MemWData = rsrcVal;
                    memWeC   = 1'b1;
                end else if (fIn) begin
                    wbEnNext   = fWb;
                    wbAddrNext = rdstAddr;
                    wbDataNext = inPort;
                end else if (fOut) begin
                    outPortNext = aluRes;
                end else if (fWb) begin
                    wbEnNext   = 1'b1;
                    wbAddrNext = rdstAddr;
                    wbDataNext = aluRes;
                end
            end
            CALL_LO: begin
                MemAddr     = spReg;
                MemWData    = callLoReg;
                memWeC      = 1'b1;
                spNext      = spDec;
                pcLoadNext  = 1'b1;
                pcValueNext = {16'b0, targetReg};
                stateNext   = IDLE;
            end
            RET_HI: begin
                spNext      = spInc;
                MemAddr     = spInc;
                memReC      = 1'b1;
                pcValueNext = {MemRData, lowReg};
`ifdef MEM_RTI_FLAGS_EN
                // RTI defers the redirect so it lands together with the flags restore
                if (rtiReg) begin
                    stallC    = 1'b1;
                    stateNext = RTI_F;
                end else begin
                    pcLoadNext = 1'b1;
                    stateNext  = IDLE;
                end
`else
                pcLoadNext = 1'b1;
                stateNext  = IDLE;
`endif
            end
`ifdef MEM_RTI_FLAGS_EN
            RTI_F: begin
                spNext         = spInc;
                MemAddr        = spInc;
                memReC         = 1'b1;
                flagsLoadNext  = 1'b1;
                flagsValueNext = MemRData[2:0];
                pcLoadNext     = 1'b1;
                stateNext      = IDLE;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateReg   <= IDLE;
            spReg      <= SP_RESET;
            lowReg     <= '0;
            callLoReg  <= '0;
            targetReg  <= '0;
            wbEnReg    <= 1'b0;
            wbAddrReg  <= '0;
            wbDataReg  <= '0;
            outPortReg <= '0;
            pcLoadReg  <= 1'b0;
            pcValueReg <= '0;
`ifdef MEM_RTI_FLAGS_EN
            rtiReg        <= 1'b0;
            flagsLoadReg  <= 1'b0;
            flagsValueReg <= '0;
`endif
        end else begin
            stateReg   <= stateNext;
            spReg      <= spNext;
            lowReg     <= lowNext;
            callLoReg  <= callLoNext;
            targetReg  <= targetNext;
            wbEnReg    <= wbEnNext;
            wbAddrReg  <= wbAddrNext;
            wbDataReg  <= wbDataNext;
            outPortReg <= outPortNext;
            pcLoadReg  <= pcLoadNext;
            pcValueReg <= pcValueNext;
`ifdef MEM_RTI_FLAGS_EN
            rtiReg        <= rtiNext;
            flagsLoadReg  <= flagsLoadNext;
            flagsValueReg <= flagsValueNext;
`endif
        end
    end

    assign MemWE   = memWeC && !Reset;
    assign MemRE   = memReC && !Reset;
    assign Stall   = stallC;
    assign WbEn    = wbEnReg;
    assign WbAddr  = wbAddrReg;
    assign WbData  = wbDataReg;
    assign FwdMem  = {wbEnReg, wbAddrReg, wbDataReg};
    assign PcLoad  = pcLoadReg;
    assign PcValue = pcValueReg;
    assign OutPort = outPortReg;
    assign SP      = spReg;
`ifdef MEM_RTI_FLAGS_EN
    assign FlagsLoad  = flagsLoadReg;
    assign FlagsValue = flagsValueReg;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (default build, RTI behaves like RET).
module tb_memory_stage;
    localparam logic [11:0] F_PUSH = 12'h800, F_POP = 12'h400, F_RET = 12'h200, F_RTI = 12'h100;
    localparam logic [11:0] F_LDD = 12'h080, F_IN = 12'h040, F_OUT = 12'h020, F_CALL = 12'h008;
    localparam logic [11:0] F_MR = 12'h004, F_MW = 12'h002, F_WB = 12'h001;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [105:0] ExIn = '0;
    logic [19:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemWE, MemRE;
    logic [15:0] MemRData;
    logic        Stall, WbEn;
    logic [2:0]  WbAddr;
    logic [15:0] WbData;
    logic [19:0] FwdMem;
    logic        PcLoad;
    logic [31:0] PcValue;
    logic [15:0] OutPort;
    logic [19:0] SP;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1048575];

    memory_stage dut (
        .CLK(CLK), .Reset(Reset), .ExIn(ExIn),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData),
        .Stall(Stall), .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData), .FwdMem(FwdMem),
        .PcLoad(PcLoad), .PcValue(PcValue), .OutPort(OutPort), .SP(SP)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (MemWE) mem[MemAddr] <= MemWData;
    assign MemRData = mem[MemAddr];

    function automatic logic [105:0] mkEx(input logic [11:0] flags, input logic [31:0] npc,
                                          input logic [15:0] rsrc, input logic [15:0] alu,
                                          input logic [2:0] rdst, input logic [15:0] inp);
        logic [105:0] e;
        e = '0;
        e[11:0]  = flags;
        e[98:83] = inp;
        e[82:51] = npc;
        e[50:35] = rsrc;
        e[34:19] = alu;
        e[15:13] = rdst;
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ExIn = '0;
        tick(); tick();
        $display("tx reset");
        checks++; if (SP !== 20'hFFFFF) begin errors++; $display("FAIL reset_sp: got %h want fffff", SP); end
        checks++; if (WbEn !== 1'b0) begin errors++; $display("FAIL reset_wben: got %b want 0", WbEn); end
        checks++; if (FwdMem !== 20'h0) begin errors++; $display("FAIL reset_fwd: got %h want 0", FwdMem); end
        checks++; if (PcLoad !== 1'b0 || PcValue !== 32'h0) begin errors++; $display("FAIL reset_pc: got %b/%h want 0/0", PcLoad, PcValue); end
        checks++; if (OutPort !== 16'h0) begin errors++; $display("FAIL reset_out: got %h want 0", OutPort); end
        checks++; if (MemWE !== 1'b0 || MemRE !== 1'b0) begin errors++; $display("FAIL reset_strobe: got we=%b re=%b want 0/0", MemWE, MemRE); end
        Reset = 1'b0;
        #1;
        checks++; if (MemWE !== 1'b0 || MemRE !== 1'b0 || Stall !== 1'b0) begin errors++; $display("FAIL bubble_comb: got we=%b re=%b st=%b want 0/0/0", MemWE, MemRE, Stall); end
        tick();
        $display("tx bubble");
        checks++; if (WbEn !== 1'b0 || FwdMem !== 20'h0) begin errors++; $display("FAIL bubble_wb: got %b/%h want 0/0", WbEn, FwdMem); end
    endtask

    task automatic test_push_pop();
        ExIn = mkEx(F_PUSH | F_MW, 32'h0, 16'h1234, 16'h0, 3'd0, 16'h0);
        #1;
        checks++; if (MemWE !== 1'b1 || MemAddr !== 20'hFFFFF || MemWData !== 16'h1234) begin errors++; $display("FAIL push_bus: got we=%b a=%h d=%h want 1/fffff/1234", MemWE, MemAddr, MemWData); end
        tick();
        $display("tx push rsrc=1234");
        checks++; if (mem[20'hFFFFF] !== 16'h1234) begin errors++; $display("FAIL push_mem: got %h want 1234", mem[20'hFFFFF]); end
        checks++; if (SP !== 20'hFFFFE) begin errors++; $display("FAIL push_sp: got %h want ffffe", SP); end
        checks++; if (WbEn !== 1'b0) begin errors++; $display("FAIL push_wben: got %b want 0", WbEn); end
        ExIn = mkEx(F_POP | F_WB, 32'h0, 16'h0, 16'h0, 3'd3, 16'h0);
        #1;
        checks++; if (MemRE !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 20'hFFFFF) begin errors++; $display("FAIL pop_bus: got re=%b we=%b a=%h want 1/0/fffff", MemRE, MemWE, MemAddr); end
        tick();
        $display("tx pop rdst=3");
        checks++; if (SP !== 20'hFFFFF) begin errors++; $display("FAIL pop_sp: got %h want fffff", SP); end
        checks++; if (FwdMem !== 20'hB1234) begin errors++; $display("FAIL pop_fwd: got %h want b1234", FwdMem); end
        checks++; if (WbData !== 16'h1234 || WbAddr !== 3'd3 || WbEn !== 1'b1) begin errors++; $display("FAIL pop_wb: got %b/%h/%h want 1/3/1234", WbEn, WbAddr, WbData); end
    endtask

    task automatic test_call();
        ExIn = mkEx(F_CALL, 32'h0001_0042, 16'h0, 16'h0300, 3'd0, 16'h0);
        #1;
        checks++; if (Stall !== 1'b1 || MemWE !== 1'b1 || MemAddr !== 20'hFFFFF || MemWData !== 16'h0001) begin errors++; $display("FAIL call_hi_bus: got st=%b we=%b a=%h d=%h want 1/1/fffff/0001", Stall, MemWE, MemAddr, MemWData); end
        tick();
        $display("tx call npc=00010042 target=0300");
        checks++; if (SP !== 20'hFFFFE || PcLoad !== 1'b0) begin errors++; $display("FAIL call_mid: got sp=%h pcl=%b want ffffe/0", SP, PcLoad); end
        // ExIn is ignored outside IDLE
        ExIn = mkEx(F_PUSH | F_WB, 32'h0, 16'hDEAD, 16'h0, 3'd1, 16'h0);
        #1;
        checks++; if (Stall !== 1'b0 || MemWE !== 1'b1 || MemAddr !== 20'hFFFFE || MemWData !== 16'h0042) begin errors++; $display("FAIL call_lo_bus: got st=%b we=%b a=%h d=%h want 0/1/ffffe/0042", Stall, MemWE, MemAddr, MemWData); end
        tick();
        checks++; if (PcLoad !== 1'b1 || PcValue !== 32'h0000_0300) begin errors++; $display("FAIL call_pc: got %b/%h want 1/00000300", PcLoad, PcValue); end
        checks++; if (SP !== 20'hFFFFD || WbEn !== 1'b0) begin errors++; $display("FAIL call_sp: got sp=%h wben=%b want ffffd/0", SP, WbEn); end
        checks++; if (mem[20'hFFFFF] !== 16'h0001 || mem[20'hFFFFE] !== 16'h0042) begin errors++; $display("FAIL call_mem: got %h %h want 0001 0042", mem[20'hFFFFF], mem[20'hFFFFE]); end
    endtask

    task automatic test_ret(input logic [11:0] flag, input logic [31:0] expPc, input string nm);
        ExIn = mkEx(flag, 32'h0, 16'h0, 16'h0, 3'd0, 16'h0);
        #1;
        checks++; if (Stall !== 1'b1 || MemRE !== 1'b1 || MemAddr !== 20'hFFFFE) begin errors++; $display("FAIL %s_lo_bus: got st=%b re=%b a=%h want 1/1/ffffe", nm, Stall, MemRE, MemAddr); end
        tick();
        $display("tx %s", nm);
        checks++; if (PcLoad !== 1'b0 || SP !== 20'hFFFFE) begin errors++; $display("FAIL %s_mid: got pcl=%b sp=%h want 0/ffffe", nm, PcLoad, SP); end
        ExIn = '0;
        #1;
        checks++; if (Stall !== 1'b0 || MemRE !== 1'b1 || MemAddr !== 20'hFFFFF) begin errors++; $display("FAIL %s_hi_bus: got st=%b re=%b a=%h want 0/1/fffff", nm, Stall, MemRE, MemAddr); end
        tick();
        checks++; if (PcLoad !== 1'b1 || PcValue !== expPc) begin errors++; $display("FAIL %s_pc: got %b/%h want 1/%h", nm, PcLoad, PcValue, expPc); end
        checks++; if (SP !== 20'hFFFFF || WbEn !== 1'b0) begin errors++; $display("FAIL %s_sp: got sp=%h wben=%b want fffff/0", nm, SP, WbEn); end
        tick();
        checks++; if (PcLoad !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b want 0", nm, PcLoad); end
    endtask

    task automatic test_rti();
        ExIn = mkEx(F_PUSH, 32'h0, 16'h1111, 16'h0, 3'd0, 16'h0);
        tick();
        ExIn = mkEx(F_PUSH, 32'h0, 16'h2222, 16'h0, 3'd0, 16'h0);
        tick();
        $display("tx push 1111, push 2222");
        test_ret(F_RTI, 32'h1111_2222, "rti");
    endtask

    task automatic test_ldd_std();
        ExIn = mkEx(F_MW, 32'h0, 16'hBEEF, 16'h0010, 3'd0, 16'h0);
        tick();
        ExIn = mkEx(F_LDD | F_MR | F_WB, 32'h0, 16'h0, 16'h0010, 3'd5, 16'h0);
        #1;
        checks++; if (MemRE !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 20'h00010) begin errors++; $display("FAIL ldd_bus: got re=%b we=%b a=%h want 1/0/00010", MemRE, MemWE, MemAddr); end
        tick();
        $display("tx ldd addr=0010");
        checks++; if (WbData !== 16'hBEEF || WbEn !== 1'b1 || WbAddr !== 3'd5) begin errors++; $display("FAIL ldd_wb: got %b/%h/%h want 1/5/beef", WbEn, WbAddr, WbData); end
        ExIn = mkEx(F_MW, 32'h0, 16'h5555, 16'h0011, 3'd2, 16'h0);
        #1;
        checks++; if (MemWE !== 1'b1 || MemRE !== 1'b0 || MemAddr !== 20'h00011 || MemWData !== 16'h5555) begin errors++; $display("FAIL std_bus: got we=%b re=%b a=%h d=%h want 1/0/00011/5555", MemWE, MemRE, MemAddr, MemWData); end
        tick();
        $display("tx std addr=0011 data=5555");
        checks++; if (WbEn !== 1'b0 || mem[20'h00011] !== 16'h5555) begin errors++; $display("FAIL std_res: got wben=%b mem=%h want 0/5555", WbEn, mem[20'h00011]); end
    endtask

    task automatic test_in_out_wb();
        ExIn = mkEx(F_IN | F_WB, 32'h0, 16'h0, 16'h0, 3'd2, 16'hABCD);
        tick();
        $display("tx in port=abcd");
        checks++; if (WbData !== 16'hABCD || WbEn !== 1'b1 || WbAddr !== 3'd2) begin errors++; $display("FAIL in_wb: got %b/%h/%h want 1/2/abcd", WbEn, WbAddr, WbData); end
        ExIn = mkEx(F_OUT, 32'h0, 16'h0, 16'h0077, 3'd0, 16'h0);
        tick();
        $display("tx out 0077");
        checks++; if (OutPort !== 16'h0077 || WbEn !== 1'b0) begin errors++; $display("FAIL out: got port=%h wben=%b want 0077/0", OutPort, WbEn); end
        ExIn = mkEx(F_WB, 32'h0, 16'h0, 16'h4321, 3'd7, 16'h0);
        tick();
        $display("tx wb 4321 -> r7");
        checks++; if (FwdMem !== 20'hF4321) begin errors++; $display("FAIL wb_fwd: got %h want f4321", FwdMem); end
    endtask

    task automatic test_priority();
        ExIn = mkEx(F_PUSH | F_POP | F_WB, 32'h0, 16'h0A0A, 16'h0, 3'd4, 16'h0);
        #1;
        checks++; if (MemWE !== 1'b1 || MemRE !== 1'b0 || MemAddr !== 20'hFFFFF) begin errors++; $display("FAIL prio_bus: got we=%b re=%b a=%h want 1/0/fffff", MemWE, MemRE, MemAddr); end
        tick();
        $display("tx push+pop+wb");
        checks++; if (SP !== 20'hFFFFE || WbEn !== 1'b0) begin errors++; $display("FAIL prio_res: got sp=%h wben=%b want ffffe/0", SP, WbEn); end
        ExIn = mkEx(F_POP, 32'h0, 16'h0, 16'h0, 3'd4, 16'h0);
        tick();
        checks++; if (WbData !== 16'h0A0A || SP !== 20'hFFFFF) begin errors++; $display("FAIL prio_pop: got %h sp=%h want 0a0a/fffff", WbData, SP); end
    endtask

    task automatic test_reset_mid();
        ExIn = mkEx(F_MW, 32'h0, 16'hCAFE, 16'h0000, 3'd0, 16'h0);
        tick();
        ExIn = mkEx(F_CALL, 32'h0002_0099, 16'h0, 16'h0500, 3'd0, 16'h0);
        tick();
        $display("tx call then reset in CALL_LO");
        Reset = 1'b1;
        ExIn = '0;
        #1;
        checks++; if (MemWE !== 1'b0 || MemRE !== 1'b0) begin errors++; $display("FAIL rst_strobe: got we=%b re=%b want 0/0", MemWE, MemRE); end
        tick();
        checks++; if (PcLoad !== 1'b0 || SP !== 20'hFFFFF) begin errors++; $display("FAIL rst_mid: got pcl=%b sp=%h want 0/fffff", PcLoad, SP); end
        Reset = 1'b0;
        #1;
        checks++; if (Stall !== 1'b0 || MemWE !== 1'b0) begin errors++; $display("FAIL rst_idle: got st=%b we=%b want 0/0", Stall, MemWE); end
        tick();
        checks++; if (PcLoad !== 1'b0 || mem[20'hFFFFF] !== 16'h0002) begin errors++; $display("FAIL rst_after: got pcl=%b mem=%h want 0/0002", PcLoad, mem[20'hFFFFF]); end
        ExIn = mkEx(F_POP, 32'h0, 16'h0, 16'h0, 3'd1, 16'h0);
        #1;
        checks++; if (MemAddr !== 20'h00000) begin errors++; $display("FAIL wrap_addr: got %h want 00000", MemAddr); end
        tick();
        $display("tx pop at fffff (wrap)");
        checks++; if (SP !== 20'h00000 || WbData !== 16'hCAFE) begin errors++; $display("FAIL wrap_pop: got sp=%h d=%h want 00000/cafe", SP, WbData); end
        ExIn = mkEx(F_PUSH, 32'h0, 16'h7777, 16'h0, 3'd0, 16'h0);
        tick();
        $display("tx push at 00000 (wrap)");
        checks++; if (SP !== 20'hFFFFF || mem[20'h00000] !== 16'h7777) begin errors++; $display("FAIL wrap_push: got sp=%h mem=%h want fffff/7777", SP, mem[20'h00000]); end
        ExIn = '0;
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_push_pop();
        test_call();
        test_ret(F_RET, 32'h0001_0042, "ret");
        test_rti();
        test_ldd_std();
        test_in_out_wb();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
